// File: rtl/image_streamer_pkg.sv
// Shared definitions for the image streamer: FSM states, frame geometry and
// bus widths used by the RTL and the top-level testbench.
package image_streamer_pkg;

  localparam int IMG_PIXELS = 784;
  localparam int PIX_W      = 8;
  localparam int PRED_W     = 4;
  localparam int CONF_W     = 8;

  localparam logic [PRED_W-1:0] PRED_INVALID = 4'hF;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    HOLD_RES = 2'd3
  } state_t;

  // Address width for a table of n entries, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_streamer_buffer.sv
// Frame buffer: one write port, one read port, registered read data so the
// array maps onto block RAM.
module frame_buffer
  import image_streamer_pkg::*;
#(
  parameter int DEPTH = IMG_PIXELS,
  parameter int AW    = cnt_width(DEPTH),
  parameter int DW    = PIX_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/image_streamer.sv
// Buffers one frame of host pixels, replays it gaplessly to the inference core,
// then holds the core's result (or a timeout marker) until the host takes it.
module image_streamer #(
  parameter int IMG_PIXELS = image_streamer_pkg::IMG_PIXELS,
  parameter int TIMEOUT    = 65535
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [image_streamer_pkg::PIX_W-1:0]  wr_data,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  output logic [image_streamer_pkg::PIX_W-1:0]  pix_data,
  output logic                                  pix_valid,
  input  logic [image_streamer_pkg::PRED_W-1:0] core_prediction,
  input  logic [image_streamer_pkg::CONF_W-1:0] core_confidence,
  input  logic                                  core_valid,
  output logic [image_streamer_pkg::PRED_W-1:0] res_prediction,
  output logic [image_streamer_pkg::CONF_W-1:0] res_confidence,
  output logic                                  res_timeout,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic                                  busy
);

  import image_streamer_pkg::*;

  localparam int AW = cnt_width(IMG_PIXELS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_PIXELS - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  state_t           state_reg;
  logic [AW-1:0]    wr_cnt_reg;
  logic [AW-1:0]    rd_cnt_reg;
  logic             rd_done_reg;
  logic             rd_vld_reg;
  logic [TW-1:0]    tcnt_reg;
  logic             wr_en;
  logic             rd_en;
  logic [PIX_W-1:0] ram_q;

  assign wr_ready = (state_reg == LOAD);
  assign busy     = (state_reg != LOAD);
  assign wr_en    = wr_ready && wr_valid;
  assign rd_en    = (state_reg == STREAM) && !rd_done_reg;

  frame_buffer #(
    .DEPTH (IMG_PIXELS),
    .AW    (AW),
    .DW    (PIX_W)
  ) u_frame_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt_reg),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_cnt_reg),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= LOAD;
      wr_cnt_reg     <= '0;
      rd_cnt_reg     <= '0;
      rd_done_reg    <= 1'b0;
      rd_vld_reg     <= 1'b0;
      tcnt_reg       <= '0;
      pix_valid      <= 1'b0;
      pix_data       <= '0;
      res_valid      <= 1'b0;
      res_timeout    <= 1'b0;
      res_prediction <= '0;
      res_confidence <= '0;
    end else begin
      // Two-stage read pipeline: RAM output register, then the pixel register.
      rd_vld_reg <= rd_en;
      pix_valid  <= rd_vld_reg;
      if (rd_vld_reg) begin
        pix_data <= ram_q;
      end

      case (state_reg)
        LOAD: begin
          if (wr_valid) begin
            if (wr_cnt_reg == LAST_ADDR) begin
              wr_cnt_reg  <= '0;
              rd_cnt_reg  <= '0;
              rd_done_reg <= 1'b0;
              state_reg   <= STREAM;
            end else begin
              wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
          end
        end

        STREAM: begin
          if (rd_en) begin
            if (rd_cnt_reg == LAST_ADDR) begin
              rd_done_reg <= 1'b1;
            end else begin
              rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
          end
          // Leave once the final pixel is on the output and nothing follows it.
          if (rd_done_reg && !rd_vld_reg && pix_valid) begin
            state_reg  <= WAIT_RES;
            rd_cnt_reg <= '0;
            tcnt_reg   <= '0;
          end
        end

        WAIT_RES: begin
          if (core_valid) begin
            res_prediction <= core_prediction;
            res_confidence <= core_confidence;
            res_timeout    <= 1'b0;
            res_valid      <= 1'b1;
            state_reg      <= HOLD_RES;
          end else if (tcnt_reg == LAST_WAIT) begin
            res_prediction <= PRED_INVALID;
            res_confidence <= '0;
            res_timeout    <= 1'b1;
            res_valid      <= 1'b1;
            state_reg      <= HOLD_RES;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end

        HOLD_RES: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= LOAD;
          end
        end

        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: pixel and result scoreboards fed at
// stimulus time and drained as the DUT produces output.
module tb_image_streamer;
  import image_streamer_pkg::*;

  localparam int TB_TIMEOUT = 100;

  typedef struct packed {
    logic [PRED_W-1:0] pred;
    logic [CONF_W-1:0] conf;
    logic              tmo;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic [PRED_W-1:0] core_prediction;
  logic [CONF_W-1:0] core_confidence;
  logic              core_valid;
  logic [PRED_W-1:0] res_prediction;
  logic [CONF_W-1:0] res_confidence;
  logic              res_timeout;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [PIX_W-1:0] pix_q[$];
  res_t             res_q[$];
  res_t             cur_res;

  image_streamer #(
    .IMG_PIXELS (IMG_PIXELS),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .core_prediction (core_prediction),
    .core_confidence (core_confidence),
    .core_valid      (core_valid),
    .res_prediction  (res_prediction),
    .res_confidence  (res_confidence),
    .res_timeout     (res_timeout),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; the expected stream is recorded only for accepted bytes.
  task automatic load_frame(input int mode, input bit gaps);
    int i = 0;
    int cyc = 0;
    logic [PIX_W-1:0] d;
    while (i < IMG_PIXELS && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       d = PIX_W'(i % 256);
        1:       d = PIX_W'($urandom_range(0, 255));
        2:       d = PIX_W'(i) ^ 8'h5A;
        default: d = 8'd255 - PIX_W'(i % 256);
      endcase
      wr_data  = d;
      wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_valid && wr_ready) begin
        pix_q.push_back(d);
        i++;
      end
    end
    chk("load_count", i, IMG_PIXELS);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    chk("wr_ready_drop", wr_ready, 0);
    chk("busy_stream", busy, 1);
    chk("pv_lat1", pix_valid, 0);
    $display("load frame mode=%0d gaps=%0d bytes=%0d", mode, gaps, i);
  endtask

  task automatic stream_check(input int n_pix, input int pulse_at);
    logic [PIX_W-1:0] e;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("pv_lat2", pix_valid, 0);
    for (int k = 0; k < n_pix; k++) begin
      @(negedge clk);
      core_valid = 1'b0;
      e = (pix_q.size() > 0) ? pix_q.pop_front() : 8'hxx;
      chk($sformatf("pv_%0d", k), pix_valid, 1);
      chk($sformatf("pix_%0d", k), pix_data, e);
      if (k == pulse_at) begin
        core_prediction = 4'd2;
        core_confidence = 8'd11;
        core_valid      = 1'b1;
      end
    end
    core_valid = 1'b0;
    $display("streamed %0d pixels", n_pix);
  endtask

  task automatic stream_end();
    @(negedge clk);
    chk("pv_end", pix_valid, 0);
    chk("no_res_stream", res_valid, 0);
    chk("busy_wait", busy, 1);
    chk("pix_q_empty", pix_q.size(), 0);
  endtask

  task automatic check_result();
    if (res_q.size() == 0) begin
      chk("res_q_nonempty", 0, 1);
    end else begin
      cur_res = res_q.pop_front();
    end
    chk("res_valid", res_valid, 1);
    chk("res_pred", res_prediction, cur_res.pred);
    chk("res_conf", res_confidence, cur_res.conf);
    chk("res_tmo", res_timeout, cur_res.tmo);
    $display("result pred=%0d conf=%0d tmo=%0d", res_prediction, res_confidence, res_timeout);
  endtask

  task automatic release_result(input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_pred", res_prediction, cur_res.pred);
      chk("hold_conf", res_confidence, cur_res.conf);
      chk("hold_tmo", res_timeout, cur_res.tmo);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("rel_valid", res_valid, 0);
    chk("rel_wr_ready", wr_ready, 1);
    chk("rel_busy", busy, 0);
    $display("result released after %0d hold cycles", hold);
  endtask

  initial begin
    rst = 1'b1;
    wr_data = '0;
    wr_valid = 1'b0;
    core_prediction = '0;
    core_confidence = '0;
    core_valid = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_tmo", res_timeout, 0);
    chk("rst_res_pred", res_prediction, 0);
    chk("rst_res_conf", res_confidence, 0);
    rst = 1'b0;

    // Core strobe while loading must be ignored.
    core_prediction = 4'd5;
    core_confidence = 8'd42;
    core_valid = 1'b1;
    @(negedge clk);
    core_valid = 1'b0;
    @(negedge clk);
    chk("load_core_ignored", res_valid, 0);
    chk("load_core_busy", busy, 0);

    // Frame A: i mod 256, stray core strobe mid-stream, core answers 7/93.
    load_frame(0, 1'b0);
    stream_check(IMG_PIXELS, 100);
    stream_end();
    core_prediction = 4'd7;
    core_confidence = 8'd93;
    core_valid = 1'b1;
    res_q.push_back('{pred: 4'd7, conf: 8'd93, tmo: 1'b0});
    @(negedge clk);
    core_valid = 1'b0;
    check_result();
    release_result(10);

    // Frame B: gapped random load, no core answer -> timeout after 100 cycles.
    load_frame(1, 1'b1);
    stream_check(IMG_PIXELS, -1);
    stream_end();
    res_q.push_back('{pred: PRED_INVALID, conf: 8'd0, tmo: 1'b1});
    for (int k = 0; k < TB_TIMEOUT - 1; k++) begin
      @(negedge clk);
      chk("tmo_wait", res_valid, 0);
    end
    @(negedge clk);
    check_result();
    release_result(2);

    // Frame C: core strobe on the very cycle the timeout would fire.
    load_frame(0, 1'b0);
    stream_check(IMG_PIXELS, -1);
    stream_end();
    for (int k = 0; k < TB_TIMEOUT - 1; k++) begin
      @(negedge clk);
      chk("tie_wait", res_valid, 0);
    end
    core_prediction = 4'd3;
    core_confidence = 8'd50;
    core_valid = 1'b1;
    res_q.push_back('{pred: 4'd3, conf: 8'd50, tmo: 1'b0});
    @(negedge clk);
    core_valid = 1'b0;
    check_result();
    release_result(1);

    // Frame D: reset while pixel 400 is on the output.
    load_frame(2, 1'b0);
    stream_check(400, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_pv", pix_valid, 0);
    chk("mid_rst_wr_ready", wr_ready, 1);
    chk("mid_rst_pix_data", pix_data, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    pix_q.delete();
    $display("reset applied at streamed pixel 400");

    // Frame E: fresh frame after the abort streams from pixel 0.
    load_frame(3, 1'b0);
    stream_check(IMG_PIXELS, -1);
    stream_end();
    core_prediction = 4'd9;
    core_confidence = 8'd100;
    core_valid = 1'b1;
    res_q.push_back('{pred: 4'd9, conf: 8'd100, tmo: 1'b0});
    @(negedge clk);
    core_valid = 1'b0;
    check_result();
    release_result(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/image_streamer.md
IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 Parameter IMG_PIXELS, default 784, sets pixels per frame (28x28).
REQ-002 Parameter TIMEOUT, default 65535, sets the maximum WAIT_RES cycles before the block abandons the frame.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wr_data  in  8  host pixel byte, unsigned grayscale.
REQ-007 wr_valid  in  1  host byte present.
REQ-008 wr_ready  out  1  block accepts a byte this cycle.
REQ-009 pix_data  out  8  pixel to the inference core's 8-bit data input.
REQ-010 pix_valid  out  1  pix_data valid; drives the core's valid_in.
REQ-011 core_prediction  in  4  core class index 0-9.
REQ-012 core_confidence  in  8  core confidence percentage.
REQ-013 core_valid  in  1  one-cycle core result strobe.
REQ-014 res_prediction  out  4  latched class index.
REQ-015 res_confidence  out  8  latched confidence.
REQ-016 res_timeout  out  1  frame abandoned; no core result received.
REQ-017 res_valid  out  1  result available to host.
REQ-018 res_ready  in  1  host consumes result.
REQ-019 busy  out  1  high in every state except LOAD.

Function
REQ-020 The FSM SHALL use four states: LOAD, STREAM, WAIT_RES and HOLD_RES.
REQ-021 LOAD: wr_ready=1; a byte transfers on wr_valid&wr_ready and is written to frame buffer address wr_cnt; wr_cnt then increments.
REQ-022 LOAD: after transfer IMG_PIXELS-1 is accepted, the FSM SHALL enter STREAM on the next edge and clear wr_cnt.
REQ-023 STREAM: wr_ready=0; the buffer is read at rd_cnt from 0 to IMG_PIXELS-1, one address per cycle, no gaps.
REQ-024 Buffer read is registered: pix_valid SHALL rise exactly 2 cycles after STREAM entry and stay high for exactly IMG_PIXELS consecutive cycles, carrying pixels in write order.
REQ-025 The cycle after the last pix_valid, the FSM SHALL enter WAIT_RES and clear the timeout counter.
REQ-026 WAIT_RES: on core_valid=1, the block SHALL latch core_prediction/core_confidence, clear res_timeout, and enter HOLD_RES.
REQ-027 WAIT_RES: if the counter reaches TIMEOUT with no core_valid, the block SHALL set res_timeout=1, set res_prediction=4'hF and res_confidence=0, and enter HOLD_RES; if core_valid arrives on that same cycle, the core result wins.
REQ-028 HOLD_RES: res_valid=1 and res_* SHALL remain stable until res_ready=1; on that edge res_valid SHALL drop and the FSM SHALL return to LOAD.
REQ-029 core_valid outside WAIT_RES SHALL be ignored, with no state or output change.
REQ-030 wr_valid outside LOAD SHALL be ignored; the host byte is not consumed.
REQ-031 Counters are $clog2(IMG_PIXELS) bits (10 at default) and $clog2(TIMEOUT+1) bits; none may wrap within a frame.

Reset
REQ-032 rst SHALL override all other inputs: state=LOAD; wr_cnt, rd_cnt and the timeout counter cleared; pix_valid, res_valid and res_timeout set to 0.
REQ-033 rst SHALL set pix_data, res_prediction and res_confidence to 0; buffer contents are not cleared.
REQ-034 rst mid-STREAM SHALL drop pix_valid on the next edge; the partially sent frame is discarded.
REQ-035 The block does not reset the core; the system drives both resets together.

Structure
REQ-036 A shared package SHALL hold the state enum, IMG_PIXELS, PRED_INVALID=4'hF and the pixel/prediction/confidence widths; these are shared with the top-level testbench.
REQ-037 The frame buffer SHALL be one sub-module, frame_buffer: single-port-write, single-port-read RAM, 8 x IMG_PIXELS, with registered read.

Verification
REQ-038 Scenario 1: reset, load 784 bytes of i mod 256 with wr_valid held high -> wr_ready drops after the 784th byte; pix_valid high 784 cycles with pix_data=i mod 256.
REQ-039 Scenario 2: inject core_valid with prediction=7, confidence=93 in WAIT_RES -> res_valid=1, res_prediction=7, res_confidence=93, res_timeout=0; hold res_ready=0 for 10 cycles -> outputs stable; pulse res_ready -> state LOAD next cycle.
REQ-040 Scenario 3: TIMEOUT=100, no core_valid -> res_timeout=1, res_prediction=4'hF, res_confidence=0 exactly 100 cycles after WAIT_RES entry.
REQ-041 Scenario 4: random wr_valid gaps (50% duty) during load -> streamed pixel order equals written order; pix_valid remains gapless.
REQ-042 Scenario 5: rst asserted at streamed pixel 400 -> pix_valid=0 next cycle, wr_ready=1; a fresh frame then streams correctly from pixel 0.
REQ-043 Scenario 6: core_valid pulsed during LOAD and during STREAM -> no res_valid; core_valid and TIMEOUT on the same cycle -> core result, res_timeout=0.
